// File: rtl/instr_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue_if
//
// Bundles every non-clock/reset signal of the instruction prefetch queue.
//   master : the prefetch queue itself (drives memory requests and the IF
//            head, receives redirect, memory responses and IF/ID ready).
//   slave  : the surroundings (EX redirect source, instruction memory,
//            IF/ID register).
//
// Signals
//   redirect_i / redirect_pc_i   flush + new fetch target (bits [1:0] ignored)
//   mem_req_valid_o / _addr_o    word fetch request, held until accepted
//   mem_req_ready_i              memory accepts the request
//   mem_rsp_valid_i / _data_i    in-order instruction response
//   if_valid_o / if_instr_o      head instruction toward IF/ID
//   if_pc_o / if_pc_plus_4_o     PC of the head and PC + 4
//   if_ready_i                   IF/ID accepts the head
//
// Optional macro PFQ_STATS_EN adds stat_redirects_o, stat_dropped_o and
// stat_starve_o.
// ----------------------------------------------------------------------------
interface instr_prefetch_queue_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus_4_o;
    logic        if_ready_i;
`ifdef PFQ_STATS_EN
    logic [31:0] stat_redirects_o;
    logic [31:0] stat_dropped_o;
    logic [31:0] stat_starve_o;
`endif

    modport master (
        input  redirect_i, redirect_pc_i,
        output mem_req_valid_o, mem_req_addr_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output if_valid_o, if_instr_o, if_pc_o, if_pc_plus_4_o,
`ifdef PFQ_STATS_EN
        output stat_redirects_o, stat_dropped_o, stat_starve_o,
`endif
        input  if_ready_i
    );

    modport slave (
        output redirect_i, redirect_pc_i,
        input  mem_req_valid_o, mem_req_addr_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  if_valid_o, if_instr_o, if_pc_o, if_pc_plus_4_o,
`ifdef PFQ_STATS_EN
        input  stat_redirects_o, stat_dropped_o, stat_starve_o,
`endif
        output if_ready_i
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Fetch front end in front of the IF/ID register. Issues sequential word
// fetches to a variable-latency, in-order memory port, keeps the returned
// instructions with their PCs in a DEPTH-slot queue and hands them to IF/ID
// over a valid/ready handshake. A redirect flushes the queue, restarts fetch
// at the new target and discards the responses of requests still in flight.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset; clears all control state
//   bus   instr_prefetch_queue_if.master (redirect, memory request/response,
//         IF head handshake; see the interface file)
//
// Parameters
//   DEPTH     queue slots and max outstanding requests (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Optional macro PFQ_STATS_EN: saturating 32-bit counters for redirect
// cycles, discarded responses and starved IF/ID cycles.
// ----------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    rst,
    instr_prefetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // RUN: no stale responses pending. DRAIN: drop_q responses still to discard.
    typedef enum logic {RUN, DRAIN} state_t;

    state_t         state_q;
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [PW-1:0]  fill_q;
    logic [CW-1:0]  count_q;     // reserved slots, filled or not
    logic [CW-1:0]  pend_q;      // reserved slots still waiting for data
    logic [CW-1:0]  drop_q;      // in-flight responses belonging to flushed requests
    logic [31:0]    fetch_pc_q;
    logic [DEPTH-1:0] filled_q;
    logic [31:0]    pc_mem    [DEPTH];
    logic [31:0]    instr_mem [DEPTH];

    logic [CW:0]      occupancy;
    logic             req_valid;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_fill;
    logic             rsp_used;
    logic             head_valid;
    logic             pop;
    logic [CW-1:0]    drop_next;
    logic [DEPTH-1:0] filled_next;
    logic             unused_pc_lsb;

    // Stale responses and live slots share the DEPTH budget, so a flushed
    // request keeps its credit until its response has come back.
    assign occupancy = {1'b0, count_q} + {1'b0, drop_q};
    assign req_valid = !rst && (occupancy < (CW+1)'(DEPTH));
    assign req_fire  = req_valid && bus.mem_req_ready_i;

    assign rsp_drop  = bus.mem_rsp_valid_i && (state_q == DRAIN);
    // A response with nothing outstanding is ignored.
    assign rsp_fill  = bus.mem_rsp_valid_i && (state_q == RUN) && (pend_q != '0);
    assign rsp_used  = rsp_drop || rsp_fill;

    assign head_valid = filled_q[head_q];
    assign pop        = head_valid && bus.if_ready_i && !bus.redirect_i;

    assign unused_pc_lsb = ^bus.redirect_pc_i[1:0];

    // On redirect every unfilled slot, plus a request accepted this very
    // cycle, turns into a response that must be thrown away.
    always_comb begin
        if (bus.redirect_i) begin
            drop_next = drop_q + pend_q + CW'(req_fire) - CW'(rsp_used);
        end else begin
            drop_next = drop_q - CW'(rsp_drop);
        end
    end

    always_comb begin
        filled_next = filled_q;
        if (pop) begin
            filled_next[head_q] = 1'b0;
        end
        if (rsp_fill) begin
            filled_next[fill_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            filled_q   <= '0;
        end else begin
            drop_q  <= drop_next;
            state_q <= (drop_next != '0) ? DRAIN : RUN;
            if (bus.redirect_i) begin
                head_q     <= '0;
                tail_q     <= '0;
                fill_q     <= '0;
                count_q    <= '0;
                pend_q     <= '0;
                filled_q   <= '0;
                fetch_pc_q <= {bus.redirect_pc_i[31:2], 2'b00};
            end else begin
                if (req_fire) begin
                    tail_q     <= tail_q + PW'(1);
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (rsp_fill) begin
                    fill_q <= fill_q + PW'(1);
                end
                if (pop) begin
                    head_q <= head_q + PW'(1);
                end
                count_q  <= count_q + CW'(req_fire) - CW'(pop);
                pend_q   <= pend_q + CW'(req_fire) - CW'(rsp_fill);
                filled_q <= filled_next;
            end
        end
    end

    // Slot payload: no reset needed, only read when the filled bit is set.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[tail_q] <= fetch_pc_q;
        end
        if (rsp_fill) begin
            instr_mem[fill_q] <= bus.mem_rsp_data_i;
        end
    end

    assign bus.mem_req_valid_o = req_valid;
    assign bus.mem_req_addr_o  = fetch_pc_q;
    assign bus.if_valid_o      = head_valid;
    assign bus.if_instr_o      = head_valid ? instr_mem[head_q] : 32'd0;
    assign bus.if_pc_o         = head_valid ? pc_mem[head_q] : 32'd0;
    assign bus.if_pc_plus_4_o  = head_valid ? pc_mem[head_q] + 32'd4 : 32'd0;

`ifdef PFQ_STATS_EN
    logic [31:0] stat_redirects_q;
    logic [31:0] stat_dropped_q;
    logic [31:0] stat_starve_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_redirects_q <= '0;
            stat_dropped_q   <= '0;
            stat_starve_q    <= '0;
        end else begin
            stat_redirects_q <= sat_inc(stat_redirects_q, bus.redirect_i);
            stat_dropped_q   <= sat_inc(stat_dropped_q, rsp_drop);
            stat_starve_q    <= sat_inc(stat_starve_q, bus.if_ready_i && !head_valid);
        end
    end

    assign bus.stat_redirects_o = stat_redirects_q;
    assign bus.stat_dropped_o   = stat_dropped_q;
    assign bus.stat_starve_o    = stat_starve_q;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Drives the prefetch queue with a randomized in-order memory, random IF/ID
// stalls and random redirects. A queue-level reference (list of reserved
// entries plus a list of in-flight memory requests) predicts all outputs each
// cycle; directed sequences pin literal addresses/PCs at known cycles.
// ----------------------------------------------------------------------------
module tb_instr_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_prefetch_queue_if bus();

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    mreq_t       mem[$];   // requests accepted by memory, not yet answered
    ent_t        mq[$];    // live queue entries, oldest first
    logic [31:0] m_pc;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // stimulus knobs
    int          lat_lo = 1, lat_hi = 1;
    int          rdy_pct = 100, ifr_pct = 100, rsp_pct = 100, rd_permil = 0;
    bit          force_rd = 0;
    logic [31:0] force_pc = '0;

`ifdef PFQ_STATS_EN
    logic [31:0] e_redirects, e_dropped, e_starve;
`endif

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: per-cycle compare at the falling edge, then advance.
    always @(negedge clk) begin : model
        int          unf;
        int          drop;
        logic        erv, eiv, rd, rf, pop;
        logic [31:0] e_instr, e_pc;
        if (rst) begin
            mq.delete();
            mem.delete();
            m_pc = RESET_PC;
`ifdef PFQ_STATS_EN
            e_redirects = '0; e_dropped = '0; e_starve = '0;
`endif
            chk("rst_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
            chk("rst_if_valid", 32'(bus.if_valid_o), 32'd0);
            chk("rst_if_pc", bus.if_pc_o, 32'd0);
        end else begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            drop    = mem.size() - unf;
            erv     = (mq.size() + drop) < DEPTH;
            eiv     = (mq.size() > 0) && mq[0].filled;
            e_instr = eiv ? mq[0].data : 32'd0;
            e_pc    = eiv ? mq[0].pc : 32'd0;
            chk("req_valid", 32'(bus.mem_req_valid_o), 32'(erv));
            if (erv) chk("req_addr", bus.mem_req_addr_o, m_pc);
            chk("if_valid", 32'(bus.if_valid_o), 32'(eiv));
            chk("if_instr", bus.if_instr_o, e_instr);
            chk("if_pc", bus.if_pc_o, e_pc);
            chk("if_pc_plus_4", bus.if_pc_plus_4_o, eiv ? e_pc + 32'd4 : 32'd0);
`ifdef PFQ_STATS_EN
            chk("stat_redirects", bus.stat_redirects_o, e_redirects);
            chk("stat_dropped", bus.stat_dropped_o, e_dropped);
            chk("stat_starve", bus.stat_starve_o, e_starve);
            if (bus.redirect_i) e_redirects++;
            if (bus.if_ready_i && !eiv) e_starve++;
`endif
            rd  = bus.redirect_i;
            rf  = erv && bus.mem_req_ready_i;
            pop = eiv && bus.if_ready_i && !rd;
            if (bus.mem_rsp_valid_i && mem.size() > 0) begin
                void'(mem.pop_front());
                if (drop > 0) begin
`ifdef PFQ_STATS_EN
                    e_dropped++;
`endif
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].data   = bus.mem_rsp_data_i;
                            break;
                        end
                    end
                end
            end
            if (rf) begin
                mem.push_back('{addr: m_pc, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
                if (!rd) mq.push_back('{pc: m_pc, data: 32'd0, filled: 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (pop) void'(mq.pop_front());
            if (rd) begin
                mq.delete();
                m_pc = {bus.redirect_pc_i[31:2], 2'b00};
            end
        end
        cyc++;
    end

    task automatic drive();
        bus.mem_req_ready_i = ($urandom_range(99) < rdy_pct);
        bus.if_ready_i      = ($urandom_range(99) < ifr_pct);
        if (force_rd) begin
            bus.redirect_i    = 1'b1;
            bus.redirect_pc_i = force_pc;
            force_rd          = 0;
        end else begin
            bus.redirect_i    = ($urandom_range(999) < rd_permil);
            bus.redirect_pc_i = $urandom;
        end
        if (mem.size() > 0 && mem[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = hash(mem[0].addr);
        end else begin
            bus.mem_rsp_valid_i = 1'b0;
            bus.mem_rsp_data_i  = $urandom;
        end
    endtask

    task automatic idle();
        bus.redirect_i      = 1'b0;
        bus.redirect_pc_i   = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
        bus.if_ready_i      = 1'b0;
    endtask

    // Advance one cycle; returns 3 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #2;
    endtask

    // Reset, then return inside cycle 0 (first cycle with rst low).
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        #2;
        chk("reset_if_valid", 32'(bus.if_valid_o), 32'd0);
        chk("reset_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
        chk("reset_if_instr", bus.if_instr_o, 32'd0);
        chk("reset_if_pc_plus_4", bus.if_pc_plus_4_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        #2;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.if_valid_o) break;
            step();
        end
        chk("wait_if_valid", 32'(bus.if_valid_o), 32'd1);
    endtask

    task automatic knobs(input int lat, input int rdy, input int ifr);
        lat_lo = lat; lat_hi = lat; rdy_pct = rdy; ifr_pct = ifr;
        rsp_pct = 100; rd_permil = 0;
    endtask

    initial begin
        idle();

        // Streaming after reset, 1-cycle memory.
        knobs(1, 100, 100);
        do_reset();
        chk("a_c0_req_valid", 32'(bus.mem_req_valid_o), 32'd1);
        chk("a_c0_addr", bus.mem_req_addr_o, 32'h0);
        step();
        chk("a_c1_addr", bus.mem_req_addr_o, 32'h4);
        chk("a_c1_if_valid", 32'(bus.if_valid_o), 32'd0);
        step();
        chk("a_c2_if_valid", 32'(bus.if_valid_o), 32'd1);
        chk("a_c2_if_pc", bus.if_pc_o, 32'h0);
        chk("a_c2_pc_plus_4", bus.if_pc_plus_4_o, 32'h4);
        chk("a_c2_addr", bus.mem_req_addr_o, 32'h8);
        step();
        chk("a_c3_if_pc", bus.if_pc_o, 32'h4);
        chk("a_c3_if_instr", bus.if_instr_o, hash(32'h4));

        // Full queue with IF/ID stalled, then a single pop.
        knobs(1, 100, 0);
        do_reset();
        repeat (4) step();
        chk("b_full_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
        repeat (2) step();
        chk("b_hold_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
        chk("b_hold_if_pc", bus.if_pc_o, 32'h0);
        ifr_pct = 100;
        step();
        chk("b_pop_if_pc", bus.if_pc_o, 32'h0);
        chk("b_pop_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
        ifr_pct = 0;
        step();
        chk("b_after_req_valid", 32'(bus.mem_req_valid_o), 32'd1);
        chk("b_after_addr", bus.mem_req_addr_o, 32'h10);
        chk("b_after_if_pc", bus.if_pc_o, 32'h4);

        // Redirect with three requests outstanding, 3-cycle memory.
        knobs(3, 100, 100);
        do_reset();
        step();
        step();
        force_rd = 1; force_pc = 32'h0000_0103; rdy_pct = 0;
        step();
        rdy_pct = 100;
        step();
        chk("c_req_valid", 32'(bus.mem_req_valid_o), 32'd1);
        chk("c_addr", bus.mem_req_addr_o, 32'h100);
        chk("c_if_valid", 32'(bus.if_valid_o), 32'd0);
        wait_valid(40);
        chk("c_first_pc", bus.if_pc_o, 32'h100);
        chk("c_first_instr", bus.if_instr_o, hash(32'h100));

        // Redirect coinciding with an IF fire and a response.
        knobs(1, 100, 100);
        do_reset();
        step();
        force_rd = 1; force_pc = 32'h0000_0200;
        step();
        chk("d_fire_if_valid", 32'(bus.if_valid_o), 32'd1);
        chk("d_fire_if_pc", bus.if_pc_o, 32'h0);
        step();
        chk("d_flushed_if_valid", 32'(bus.if_valid_o), 32'd0);
        chk("d_addr", bus.mem_req_addr_o, 32'h200);
        wait_valid(20);
        chk("d_first_pc", bus.if_pc_o, 32'h200);
        step();
        chk("d_second_pc", bus.if_pc_o, 32'h204);

        // Memory not ready for 5 cycles: address held.
        knobs(1, 100, 100);
        do_reset();
        step();
        rdy_pct = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("e_stall_addr", bus.mem_req_addr_o, 32'h8);
            chk("e_stall_valid", 32'(bus.mem_req_valid_o), 32'd1);
        end
        rdy_pct = 100;
        step();
        chk("e_release_addr", bus.mem_req_addr_o, 32'h8);
        step();
        chk("e_next_addr", bus.mem_req_addr_o, 32'hC);

        // Address wrap at the top of the address space.
        knobs(1, 100, 100);
        do_reset();
        step();
        force_rd = 1; force_pc = 32'hFFFF_FFFE;
        step();
        step();
        chk("f_addr_top", bus.mem_req_addr_o, 32'hFFFF_FFFC);
        step();
        chk("f_addr_wrap", bus.mem_req_addr_o, 32'h0);
        wait_valid(20);
        chk("f_pc_top", bus.if_pc_o, 32'hFFFF_FFFC);
        chk("f_pc_plus_4_wrap", bus.if_pc_plus_4_o, 32'h0);
        step();
        chk("f_pc_wrapped", bus.if_pc_o, 32'h0);

        // Randomized segments, occasional mid-operation reset.
        for (int seg = 0; seg < 20; seg++) begin
            lat_lo    = $urandom_range(2, 1);
            lat_hi    = lat_lo + int'($urandom_range(3, 0));
            rdy_pct   = $urandom_range(100, 30);
            ifr_pct   = $urandom_range(100, 20);
            rsp_pct   = $urandom_range(100, 50);
            rd_permil = $urandom_range(60, 0);
            if (seg % 5 == 4) do_reset();
            repeat (300) step();
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Fetch front end that sits directly upstream of the pipeline's IF/ID register. It replaces the combinational instruction-memory lookup with a request/response memory port that can have variable latency. The block issues sequential word fetches, buffers the returned instructions in order together with their PCs, and presents them to the IF/ID register through a valid/ready handshake. A redirect from EX (taken branch, JAL, JALR) flushes the queue and restarts fetch at the new target.

Parameters:
DEPTH, 4, number of queue slots; must be a power of 2, at least 2; also the maximum number of outstanding memory requests.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high; clears all state.
redirect_i  in  1  flush the queue and restart fetch this cycle.
redirect_pc_i  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
mem_req_valid_o  out  1  fetch request valid.
mem_req_addr_o  out  32  fetch word address (byte address, bits [1:0]=0).
mem_req_ready_i  in  1  memory accepts the request.
mem_rsp_valid_i  in  1  response valid; responses return in request order, at least 1 cycle after the request is accepted.
mem_rsp_data_i  in  32  instruction word.
if_valid_o  out  1  head instruction valid.
if_instr_o  out  32  head instruction.
if_pc_o  out  32  PC of the head instruction.
if_pc_plus_4_o  out  32  if_pc_o + 4 (wraps modulo 2^32).
if_ready_i  in  1  IF/ID accepts the head; low means stall.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC; queue empty; drop_cnt = 0.
  - if_valid_o = 0; if_instr_o, if_pc_o, if_pc_plus_4_o = 0 while empty.
  - mem_req_valid_o = 0 while rst is high.
- Reset mid-operation: any outstanding responses are forgotten. The bench's memory model must also reset.
- Slot allocation:
  - A slot is reserved at request issue and stores the request PC.
  - It is marked filled when the matching response arrives.
  - count = number of reserved slots (filled or not); width clog2(DEPTH)+1.
- Request issue:
  - mem_req_valid_o = !rst && (count + drop_cnt) < DEPTH; mem_req_addr_o = fetch_pc.
  - On req fire (valid && ready): reserve tail slot with PC = fetch_pc; fetch_pc += 4 (wraps modulo 2^32).
  - The request stays asserted with a stable address until accepted, unless a redirect intervenes.
- Response:
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: write the data into the oldest unfilled slot and mark it filled.
  - A response with no outstanding request is ignored; the bench flags it as an error.
- Delivery:
  - if_valid_o = head slot filled; the outputs are registered slot contents.
  - A response arriving in cycle N appears on if_* in cycle N+1.
  - On if fire (if_valid_o && if_ready_i), pop the head.
  - If if_ready_i is low, the head is held and if_* outputs stay stable.
- Full: when count + drop_cnt == DEPTH, mem_req_valid_o = 0. Pop and issue in the same cycle are allowed; count is unchanged.
- Empty: if_valid_o = 0; a reserved-but-unfilled head also gives if_valid_o = 0.
- Pointers: head, tail and fill pointers are clog2(DEPTH) bits and wrap naturally.
- Redirect (highest priority):
  - Next cycle: queue empty (count = 0); fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - drop_cnt_next = drop_cnt + (unfilled reserved slots) + req_fire − rsp_fire. A request accepted in the redirect cycle is therefore dropped.
  - A pop in the same cycle is a no-op, since the queue is flushed.
  - if_valid_o = 0 in the cycle after a redirect.
  - Requests to the new target may issue from the cycle after the redirect, provided count + drop_cnt < DEPTH.
  - Back-to-back redirects accumulate into drop_cnt; the last target wins.
- State machine (state_q):
  - RUN: drop_cnt == 0.
  - DRAIN: drop_cnt > 0; requests are still issued.
  - RUN→DRAIN on a redirect with in-flight requests.
  - DRAIN→RUN when drop_cnt reaches 0.

Optional Feature:
PFQ_STATS_EN
- Defined: adds three 32-bit outputs, each saturating at 32'hFFFF_FFFF and reset to 0:
  - stat_redirects_o: redirect cycles.
  - stat_dropped_o: discarded responses.
  - stat_starve_o: cycles with if_ready_i=1 and if_valid_o=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset release with a 1-cycle memory and if_ready_i=1 → requests go to addresses 0x0, 0x4, 0x8, ... on consecutive cycles. First if_valid_o appears 2 cycles after the first request, with if_pc_o=0x0 and if_pc_plus_4_o=0x4. Thereafter one instruction per cycle, in order.
2. DEPTH=4, if_ready_i=0, immediate memory → exactly 4 requests (0x0–0xC), then mem_req_valid_o=0. Raising if_ready_i for 1 cycle pops 0x0 and allows request 0x10.
3. Memory with 3-cycle latency, 3 requests outstanding; redirect_i=1, redirect_pc_i=0x103 → drop_cnt=3 (plus 1 if a request is accepted that cycle). The next request address is 0x100. Old responses are never seen on if_*. The first delivered if_pc_o is 0x100.
4. Redirect in the same cycle as an if fire and a response → the queue is empty next cycle, the response is discarded, and nothing is popped twice.
5. mem_req_ready_i held low for 5 cycles → mem_req_addr_o stays stable at 0x8; fetch_pc does not advance.
6. fetch_pc=0xFFFF_FFFC → the next request address is 0x0; if_pc_plus_4_o for the 0xFFFF_FFFC instruction is 0x0.
